// File: rtl/fp_div.sv
// -----------------------------------------------------------------------------
// fp_div : IEEE-754 single-precision divider, y = a / b
//
// Iterative restoring mantissa divider producing one quotient bit per clock.
// Every operand class, specials included, takes the same number of cycles.
// The result is truncated (round toward zero). Denormal inputs are treated as
// zero, and results that would be denormal flush to signed zero.
//
// Ports
//   clk    in   1   system clock, all state on the rising edge
//   rst    in   1   synchronous reset, active-high (aborts an operation)
//   start  in   1   request, sampled only in IDLE; latches a and b
//   a      in   32  dividend, IEEE-754 single
//   b      in   32  divisor, IEEE-754 single
//   busy   out  1   high from the edge accepting start until the edge raising done
//   done   out  1   one-cycle pulse; y valid from here until the next accepted start
//   y      out  32  quotient, IEEE-754 single
//
// Timing: start accepted at edge E0 -> done is high after edge E0+QBITS+2.
// -----------------------------------------------------------------------------
module fp_div #(
  parameter int          QBITS     = 25,
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] y
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_DIV   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Latched operands
  logic [31:0] a_reg, b_reg;

  // Division datapath
  logic [24:0]       rem_reg;     // partial remainder
  logic [23:0]       mb_reg;      // divisor significand
  logic [24:0]       q_reg;       // quotient bits, MSB first
  logic [4:0]        cnt_reg;     // DIV step counter
  logic signed [9:0] exp_reg;     // biased exponent before normalisation
  logic              sign_reg;
  logic              special_reg; // special-case result overrides NORM
  logic [31:0]       special_val_reg;
  logic [31:0]       y_reg;

  // ---------------------------------------------------------------------------
  // Operand unpack / classification (index 0 = a, index 1 = b)
  // ---------------------------------------------------------------------------
  logic [1:0][31:0] opnd;
  logic [1:0][7:0]  exp_f;
  logic [1:0][23:0] mant;
  logic [1:0]       is_zero;
  logic [1:0]       is_inf;
  logic [1:0]       is_nan;

  assign opnd[0] = a_reg;
  assign opnd[1] = b_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    assign exp_f[gi]   = opnd[gi][30:23];
    assign mant[gi]    = {1'b1, opnd[gi][22:0]};
    // Exponent 0 covers both true zero and denormals; both behave as zero.
    assign is_zero[gi] = (opnd[gi][30:23] == 8'h00);
    assign is_inf[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] == 23'h0);
    assign is_nan[gi]  = (opnd[gi][30:23] == 8'hFF) && (opnd[gi][22:0] != 23'h0);
  end

  logic              sign_calc;
  logic signed [9:0] exp_calc;
  logic              special_hit;
  logic [31:0]       special_val;

  assign sign_calc = a_reg[31] ^ b_reg[31];
  assign exp_calc  = $signed({2'b00, exp_f[0]}) - $signed({2'b00, exp_f[1]}) + 10'sd127;

  // Special operands, highest priority first.
  always_comb begin
    special_hit = 1'b1;
    special_val = 32'h0;
    if (is_nan[0] || is_nan[1]) begin
      special_val = NAN_VALUE;
    end else if ((is_inf[0] && is_inf[1]) || (is_zero[0] && is_zero[1])) begin
      special_val = NAN_VALUE;
    end else if (is_inf[0]) begin
      special_val = {sign_calc, 8'hFF, 23'h0};
    end else if (is_inf[1]) begin
      special_val = {sign_calc, 31'h0};
    end else if (is_zero[1]) begin
      special_val = {sign_calc, 8'hFF, 23'h0};
    end else if (is_zero[0]) begin
      special_val = {sign_calc, 31'h0};
    end else begin
      special_hit = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One restoring division step
  // ---------------------------------------------------------------------------
  logic [25:0] diff;
  logic        ge;
  logic [24:0] rem_next;
  logic [24:0] q_next;

  // A 26-bit difference lets the borrow bit decide rem >= mb directly.
  assign diff     = {1'b0, rem_reg} - {2'b00, mb_reg};
  assign ge       = ~diff[25];
  // After a successful subtract the remainder is below mb (< 2^24), so the
  // left shift never loses a significant bit.
  assign rem_next = (ge ? diff[24:0] : rem_reg) << 1;
  assign q_next   = {q_reg[23:0], ge};

  // ---------------------------------------------------------------------------
  // Normalisation of the finished quotient
  // ---------------------------------------------------------------------------
  logic signed [9:0] exp_norm;
  logic [22:0]       frac_norm;
  logic [31:0]       norm_result;

  // q lies in [2^23, 2^25); its top bit tells whether a/b mantissa ratio >= 1.
  assign exp_norm  = q_reg[24] ? exp_reg : (exp_reg - 10'sd1);
  assign frac_norm = q_reg[24] ? q_reg[23:1] : q_reg[22:0];

  always_comb begin
    if (exp_norm >= 10'sd255) begin
      norm_result = {sign_reg, 8'hFF, 23'h0};
    end else if (exp_norm <= 10'sd0) begin
      norm_result = {sign_reg, 31'h0};
    end else begin
      norm_result = {sign_reg, exp_norm[7:0], frac_norm};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_SETUP;
      S_SETUP: state_next = S_DIV;
      S_DIV:   if (cnt_reg == 5'(QBITS - 1)) state_next = S_NORM;
      S_NORM:  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      S_SETUP, S_DIV, S_NORM: busy = 1'b1;
      S_DONE:                 done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg           <= 32'h0;
      b_reg           <= 32'h0;
      rem_reg         <= 25'h0;
      mb_reg          <= 24'h0;
      q_reg           <= 25'h0;
      cnt_reg         <= 5'd0;
      exp_reg         <= 10'sd0;
      sign_reg        <= 1'b0;
      special_reg     <= 1'b0;
      special_val_reg <= 32'h0;
      y_reg           <= 32'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
          end
        end
        S_SETUP: begin
          // Dividend {ma, 24'b0}: the low zeros are shifted in by the steps,
          // so the remainder starts as ma alone.
          rem_reg         <= {1'b0, mant[0]};
          mb_reg          <= mant[1];
          q_reg           <= 25'h0;
          cnt_reg         <= 5'd0;
          exp_reg         <= exp_calc;
          sign_reg        <= sign_calc;
          special_reg     <= special_hit;
          special_val_reg <= special_val;
        end
        S_DIV: begin
          rem_reg <= rem_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + 5'd1;
        end
        S_NORM: begin
          // Only write of y: the edge entering DONE.
          y_reg <= special_reg ? special_val_reg : norm_result;
        end
        default: ;
      endcase
    end
  end

  assign y = y_reg;

endmodule

// File: tb/tb_fp_div.sv
// -----------------------------------------------------------------------------
// tb_fp_div : self-checking bench for fp_div.
// Directed operands with hand-derived results, control-path scenarios
// (ignored start, mid-operation reset), then random operands checked against
// an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] y;

  int total  = 0;
  int passed = 0;

  localparam int LATENCY = 27;

  fp_div dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact quotient ma/mb * 2^(ea-eb), truncated to 24 significant bits.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] z);
    logic   s;
    int     ex, ez, e;
    logic [22:0] fx, fz;
    longint mx, mz, m;
    logic [63:0] mv;
    logic [31:0] inf_v, zero_v;
    s  = x[31] ^ z[31];
    ex = int'(x[30:23]);
    ez = int'(z[30:23]);
    fx = x[22:0];
    fz = z[22:0];
    inf_v  = {s, 8'hFF, 23'h0};
    zero_v = {s, 31'h0};
    if ((ex == 255 && fx != 0) || (ez == 255 && fz != 0)) return 32'h7FC00000;
    if ((ex == 255 && ez == 255) || (ex == 0 && ez == 0)) return 32'h7FC00000;
    if (ex == 255) return inf_v;
    if (ez == 255) return zero_v;
    if (ez == 0)   return inf_v;
    if (ex == 0)   return zero_v;
    mx = longint'(fx) + (64'sd1 <<< 23);
    mz = longint'(fz) + (64'sd1 <<< 23);
    e  = ex - ez + 127;
    if (mx >= mz) begin
      m = (mx <<< 23) / mz;          // ratio in [1,2): 23 fraction bits
    end else begin
      m = (mx <<< 24) / mz;          // ratio in [0.5,1): one more bit, exponent down
      e = e - 1;
    end
    if (e >= 255) return inf_v;
    if (e <= 0)   return zero_v;
    mv = 64'(m);
    return {s, 8'(e), mv[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0]  e;
    logic [22:0] f;
    int          r;
    r = int'($urandom_range(0, 15));
    f = 23'($urandom);
    case (r)
      0:       e = 8'h00;                                  // zero / denormal
      1:       begin e = 8'hFF; f = 23'h0; end             // infinity
      2:       begin e = 8'hFF; f = f | 23'h1; end         // NaN
      3:       e = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFE;
      4:       e = 8'($urandom_range(1, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Runs one operation; optionally pulses start at op cycle pulse_at (ignored by DUT),
  // and also pulses start during the done cycle (must be ignored too).
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp_y, input int pulse_at);
    int cyc, busy_cnt;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      if (cyc == pulse_at) begin
        start = 1'b1; a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      check_val({tag, "_timeout"}, 32'(cyc), 32'(LATENCY));
      return;
    end
    $display("op %s: %h / %h -> %h (expected %h) latency %0d", tag, ia, ib, y, exp_y, cyc);
    check_val({tag, "_y"}, y, exp_y);
    check_val({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LATENCY));
    check_val({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    // start during the DONE cycle must be ignored
    start = 1'b1; a = $urandom; b = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val({tag, "_done_pulse"}, 32'(done), 32'd0);
    check_val({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    check_val({tag, "_y_hold"}, y, exp_y);
  endtask

  task automatic reset_mid_op(input logic [31:0] ia, input logic [31:0] ib);
    logic seen;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("op rst_mid: reset applied at cycle 10, busy=%0b done=%0b y=%h", busy, done, y);
    check_val("rst_mid_busy", 32'(busy), 32'd0);
    check_val("rst_mid_done", 32'(done), 32'd0);
    check_val("rst_mid_y", y, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    check_val("rst_mid_no_done", 32'(seen), 32'd0);
  endtask

  logic [31:0] dir_a [13] = '{32'h3F800000, 32'h40C00000, 32'hC0C00000, 32'h3F800000,
                              32'h3F800000, 32'h00000000, 32'h7F800000, 32'h3F800000,
                              32'h7FC00000, 32'h7F000000, 32'h00800000, 32'h00400000,
                              32'hBF800000};
  logic [31:0] dir_b [13] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000,
                              32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                              32'h40000000, 32'h00800000, 32'h7F000000, 32'h3F800000,
                              32'h00000000};
  logic [31:0] dir_y [13] = '{32'h3F800000, 32'h40400000, 32'hC0400000, 32'h3EAAAAAA,
                              32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h00000000,
                              32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000,
                              32'hFF800000};

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = 32'h0; b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_y", y, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_y[i], -1);
    end

    // start pulsed mid-operation: no effect on result or timing
    run_op("pulse5", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 5);

    reset_mid_op(32'h40C00000, 32'h40000000);
    run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, -1);

    for (int i = 0; i < 150; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      run_op($sformatf("rnd%0d", i), ra, rb, ref_div(ra, rb), -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
